// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame transmitter.
// Optional parity support is enabled elsewhere by defining UART_FRAME_TX_PARITY_EN.
package uart_pkg;

   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } uart_tx_state_e;

   // Unused upper bits are zero, so they do not disturb the XOR reduction.
   function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts while en is high, clears while low, and pulses tick
// on the last clock of each CLKS_PER_BIT-long bit period.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-word UART transmitter: latches a NUM_BYTES-word frame and sends it LSB first.
// Define UART_FRAME_TX_PARITY_EN to insert a parity bit after each word's data bits.
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int NUM_BYTES    = 12,
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [NUM_BYTES-1:0][DATA_BITS-1:0]  cmd_buf,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 data_out
);

   localparam int WORD_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_BYTES - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
   localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

   uart_tx_state_e                        state;
   logic [NUM_BYTES-1:0][DATA_BITS-1:0]   frame_q;
   logic [WORD_W-1:0]                     word_idx;
   logic [BIT_W-1:0]                      bit_idx;
   logic [BIT_W-1:0]                      bit_nxt;
   logic                                  stop_cnt;
   logic [DATA_BITS-1:0]                  cur_word;
   logic                                  tick;

   assign cur_word = frame_q[word_idx];
   assign bit_nxt  = bit_idx + 1'b1;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (state != TX_IDLE),
      .tick (tick)
   );

   // data_out is always loaded with the level of the state being entered, so the line
   // changes exactly on the bit boundary; the timer keeps running across bits and words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         frame_q  <= '0;
         word_idx <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_out <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            TX_IDLE: begin
               if (start) begin
                  frame_q  <= cmd_buf;
                  word_idx <= '0;
                  bit_idx  <= '0;
                  stop_cnt <= 1'b0;
                  busy     <= 1'b1;
                  data_out <= 1'b0;
                  state    <= TX_START;
               end
            end
            TX_START: begin
               if (tick) begin
                  bit_idx  <= '0;
                  data_out <= cur_word[0];
                  state    <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tick) begin
                  if (bit_idx == LAST_BIT) begin
`ifdef UART_FRAME_TX_PARITY_EN
                     data_out <= parity_calc(MAX_DATA_BITS'(cur_word), 1'(PARITY_ODD));
                     state    <= TX_PARITY;
`else
                     data_out <= 1'b1;
                     stop_cnt <= 1'b0;
                     state    <= TX_STOP;
`endif
                  end else begin
                     bit_idx  <= bit_nxt;
                     data_out <= cur_word[bit_nxt];
                  end
               end
            end
`ifdef UART_FRAME_TX_PARITY_EN
            TX_PARITY: begin
               if (tick) begin
                  data_out <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= TX_STOP;
               end
            end
`endif
            TX_STOP: begin
               if (tick) begin
                  if (stop_cnt == LAST_STOP) begin
                     stop_cnt <= 1'b0;
                     if (word_idx == LAST_WORD) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        data_out <= 1'b1;
                        state    <= TX_IDLE;
                     end else begin
                        word_idx <= word_idx + 1'b1;
                        data_out <= 1'b0;
                        state    <= TX_START;
                     end
                  end else begin
                     stop_cnt <= stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               busy     <= 1'b0;
               data_out <= 1'b1;
               state    <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Randomised bench for uart_frame_tx: two configurations checked cycle by cycle
// against a bit-sequence model built from the frame format rules.
module tb_uart_frame_tx;

   localparam int A_N = 2,  A_D = 8, A_C = 4, A_S = 1;
   localparam int B_N = 12, B_D = 7, B_C = 1, B_S = 2;
`ifdef UART_FRAME_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   logic                         start_a, busy_a, done_a, data_out_a;
   logic [A_N-1:0][A_D-1:0]      cmd_a;
   logic                         start_b, busy_b, done_b, data_out_b;
   logic [B_N-1:0][B_D-1:0]      cmd_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_frame_tx #(
      .NUM_BYTES(A_N), .DATA_BITS(A_D), .CLKS_PER_BIT(A_C), .STOP_BITS(A_S), .PARITY_ODD(0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .cmd_buf(cmd_a),
      .busy(busy_a), .done(done_a), .data_out(data_out_a)
   );

   uart_frame_tx #(
      .NUM_BYTES(B_N), .DATA_BITS(B_D), .CLKS_PER_BIT(B_C), .STOP_BITS(B_S), .PARITY_ODD(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .cmd_buf(cmd_b),
      .busy(busy_b), .done(done_b), .data_out(data_out_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transmitted order of one word: bit 0 is the start bit, then data LSB first,
   // optional parity, then stop bits.
   function automatic logic [31:0] word_bits(input logic [31:0] w, input int dbits,
                                             input int stops, input bit odd);
      logic [31:0] data;
      logic [31:0] pat;
      int pos;
      data = w & ((32'd1 << dbits) - 1);
      pat  = data << 1;
      pos  = dbits + 1;
      if (P == 1) begin
         pat[pos] = (($countones(data) % 2) == 1) ^ odd;
         pos++;
      end
      for (int s = 0; s < stops; s++) pat[pos + s] = 1'b1;
      return pat;
   endfunction

   task automatic send_a(input logic [A_N-1:0][A_D-1:0] f, input bit disturb, input string tag);
      bit q[$];
      logic [31:0] pat;
      int wlen;
      wlen = 1 + A_D + P + A_S;
      for (int w = 0; w < A_N; w++) begin
         pat = word_bits(32'(f[w]), A_D, A_S, 1'b0);
         for (int b = 0; b < wlen; b++) repeat (A_C) q.push_back(pat[b]);
      end
      check({tag, "_idle"}, 32'(data_out_a), 32'd1);
      cmd_a   = f;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int k = 0; k < q.size(); k++) begin
         check({tag, "_line"}, 32'(data_out_a), 32'(q[k]));
         check({tag, "_busy"}, 32'(busy_a), 32'd1);
         check({tag, "_done"}, 32'(done_a), 32'd0);
         if (disturb && k == q.size() / 3) begin
            cmd_a   = ~f;
            start_a = 1'b1;
         end
         if (disturb && k == q.size() / 3 + 1) start_a = 1'b0;
         @(negedge clk);
      end
      check({tag, "_done_pulse"}, 32'(done_a), 32'd1);
      check({tag, "_busy_end"}, 32'(busy_a), 32'd0);
      check({tag, "_line_end"}, 32'(data_out_a), 32'd1);
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done_a), 32'd0);
      check({tag, "_no_refire"}, 32'(busy_a), 32'd0);
      check({tag, "_line_idle"}, 32'(data_out_a), 32'd1);
   endtask

   task automatic stream_b(input int frames);
      logic [B_N-1:0][B_D-1:0] cur;
      logic [B_N-1:0][B_D-1:0] nxt;
      bit q[$];
      logic [31:0] pat;
      int wlen;
      wlen = 1 + B_D + P + B_S;
      for (int w = 0; w < B_N; w++) cur[w] = B_D'($urandom);
      nxt     = cur;
      cmd_b   = cur;
      start_b = 1'b1;
      @(negedge clk);
      for (int fr = 0; fr < frames; fr++) begin
         q.delete();
         for (int w = 0; w < B_N; w++) begin
            pat = word_bits(32'(cur[w]), B_D, B_S, 1'b1);
            for (int b = 0; b < wlen; b++) repeat (B_C) q.push_back(pat[b]);
         end
         for (int k = 0; k < q.size(); k++) begin
            check("b_line", 32'(data_out_b), 32'(q[k]));
            check("b_done", 32'(done_b), 32'd0);
            if (k == q.size() / 2) begin
               for (int w = 0; w < B_N; w++) nxt[w] = B_D'($urandom);
               cmd_b = nxt;
            end
            @(negedge clk);
         end
         check("b_done_pulse", 32'(done_b), 32'd1);
         check("b_gap_line", 32'(data_out_b), 32'd1);
         check("b_gap_busy", 32'(busy_b), 32'd0);
         if (fr == frames - 1) start_b = 1'b0;
         cur = nxt;
         @(negedge clk);
      end
      check("b_stop_line", 32'(data_out_b), 32'd1);
      check("b_stop_busy", 32'(busy_b), 32'd0);
   endtask

   initial begin
      logic [A_N-1:0][A_D-1:0] fa;

      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      cmd_a   = '0;
      cmd_b   = '0;
      repeat (3) @(negedge clk);
      check("rst_line_a", 32'(data_out_a), 32'd1);
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_done_a", 32'(done_a), 32'd0);
      check("rst_line_b", 32'(data_out_b), 32'd1);
      check("rst_busy_b", 32'(busy_b), 32'd0);
      check("rst_done_b", 32'(done_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send_a({8'hA5, 8'h3C}, 1'b0, "a_fixed");
      send_a({8'h00, 8'h07}, 1'b0, "a_par07");

      for (int i = 0; i < 3; i++) begin
         for (int w = 0; w < A_N; w++) fa[w] = A_D'($urandom);
         send_a(fa, (i != 0), "a_rand");
      end

      stream_b(3);

      // Abort in the middle of the data bits of word 0.
      for (int w = 0; w < A_N; w++) fa[w] = A_D'($urandom);
      cmd_a   = fa;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2 * A_C + 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_line", 32'(data_out_a), 32'd1);
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_done", 32'(done_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * A_C) @(negedge clk);
      check("post_abort_line", 32'(data_out_a), 32'd1);
      check("post_abort_busy", 32'(busy_a), 32'd0);
      check("post_abort_done", 32'(done_a), 32'd0);

      for (int w = 0; w < A_N; w++) fa[w] = A_D'($urandom);
      send_a(fa, 1'b0, "a_recover");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
